pwm_duty_meter: RTL and testbench
=================================

// Module: pwm_duty_meter
// PURPOSE
//  Receive side of the PWM link: samples an incoming PWM waveform and measures its period and duty.
//  Reports duty as an integer percent 0..100, rounded to nearest, plus period in clk_main cycles.
//  Sits between the PWM pin/filter input and downstream control logic.
//  Reports stuck-high and stuck-low lines via timeout.
// PARAMETERS
//  N        512      nominal PWM period in clk_main cycles (matches generator)
//  CNT_W    16       width of high-time/period counters; must satisfy TIMEOUT < 2**CNT_W
//  TIMEOUT  4*N      cycles without a rising edge before a stuck condition is declared
// PORTS
//  clk_main   in   1       system clock; all logic on posedge
//  rst        in   1       asynchronous, active-high reset
//  pwm_in     in   1       asynchronous PWM input
//  duty_pct   out  7       last measured duty, percent 0..100
//  period     out  CNT_W   last measured period, clk_main cycles
//  meas_valid out  1       1-cycle strobe: duty_pct/period/stuck_* just updated
//  stuck_hi   out  1       level: input held high >= TIMEOUT cycles
//  stuck_lo   out  1       level: input held low  >= TIMEOUT cycles
//  overrun    out  1       1-cycle strobe: period completed while divider busy; measurement dropped
// BEHAVIOUR
//  Reset: all outputs 0; counters 0; FSM=IDLE; synchronizer flops 0.
//  Input path: 2-FF synchronizer, then edge detect on synced signal (3 cycles pin-to-edge).
//  Rising edge = period boundary. hi_cnt counts synced-high cycles, per_cnt counts all cycles,
//   both saturate at 2**CNT_W-1; both restart at 1 on the boundary cycle.
//  FSM: IDLE -(rise)-> MEAS; MEAS -(rise)-> MEAS, latching {hi_cnt,per_cnt} and starting divider;
//   MEAS -(per_cnt==TIMEOUT)-> STUCK; STUCK -(rise)-> MEAS.
//  First rising edge after reset or after STUCK gives no measurement (partial period).
//  Divide: duty = (hi*100 + per/2) / per, CNT_W+7-bit dividend, restoring divider,
//   1 quotient bit per cycle, latency CNT_W+7 cycles from latch to meas_valid. Result clamped to 100.
//  On divider done: duty_pct, period updated, stuck_hi=stuck_lo=0, meas_valid=1 for one cycle.
//  Boundary while divider busy: counters restart normally, result discarded, overrun=1 one cycle;
//   in-flight division completes unaffected.
//  Entering STUCK: stuck_hi=1,duty_pct=100 if synced input high, else stuck_lo=1,duty_pct=0;
//   period=TIMEOUT; meas_valid=1 once; in-flight division aborted silently.
//  Leaving STUCK (rise): stuck flags held until next valid measurement.
//  Rise on same cycle as timeout: rise wins (stay MEAS, no stuck).
//  rst mid-operation: immediate return to reset state, any division abandoned, no strobe.
// STRUCTURE
//  Shared package pwm_pkg: N default, PCT_W=7, PCT_MAX=100, FSM state enum {IDLE,MEAS,STUCK}.
//  Sub-module seq_divider (params DW, QW): start/busy/done, dividend, divisor, quotient;
//   abort input for STUCK entry. Synchronizer, edge detect, counters, FSM in top.
// TESTING
//  1 N=512, high 256 cycles per period, 4 periods -> meas_valid x3, duty_pct=50, period=512.
//  2 high 128/period 512 -> 25; high 3/period 512 -> 1 (rounding); high 512 (no low) treated as stuck.
//  3 pwm_in held high 2048+ cycles after edges -> stuck_hi=1, duty_pct=100, period=2048, one strobe;
//    then 50% waveform -> first period discarded, next strobe clears stuck_hi, duty_pct=50.
//  4 period 10 cycles, high 5 -> overrun pulses on boundaries hitting busy divider; each completed
//    result 50, no hang.
//  5 assert rst during division -> all outputs 0 next cycle, no meas_valid; resume gives correct 50.
//  6 pwm_in held low from reset 2048 cycles -> stays IDLE, no strobe; first rise then 30% -> 30.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and FSM state type for the PWM receive path.
package pwm_pkg;

  localparam int unsigned N_DEF   = 512;
  localparam int unsigned PCT_W   = 7;
  localparam int unsigned PCT_MAX = 100;

  typedef enum logic [1:0] {
    IDLE,
    MEAS,
    STUCK
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle; result is presented
// combinationally on the final step so the caller can register it directly.
module seq_divider #(
  parameter int unsigned DW = 16,
  parameter int unsigned QW = 23
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [QW-1:0] i_dividend,
  input  logic [DW-1:0] i_divisor,
  output logic          o_busy,
  output logic          o_done,
  output logic [QW-1:0] o_quotient
);

  localparam int unsigned CW = $clog2(QW + 1);

  logic [DW-1:0] r_div;
  logic [DW-1:0] r_rem;
  logic [QW-1:0] r_quo;
  logic [CW-1:0] r_cnt;
  logic          r_busy;

  logic [DW:0]   w_shift;
  logic [DW-1:0] w_diff;
  logic          w_ge;
  logic          w_last;

  always_comb begin
    w_shift = {r_rem, r_quo[QW-1]};
    w_ge    = (w_shift >= {1'b0, r_div});
    w_diff  = w_shift[DW-1:0] - r_div;
    w_last  = r_busy && (r_cnt == CW'(1));
  end

  // The final step frees the unit in the same cycle so a new start is accepted.
  assign o_busy     = r_busy && !w_last;
  assign o_done     = w_last;
  assign o_quotient = {r_quo[QW-2:0], w_ge};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start && !o_busy) begin
      r_div  <= i_divisor;
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_cnt  <= CW'(QW);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem <= w_ge ? w_diff : w_shift[DW-1:0];
      r_quo <= {r_quo[QW-2:0], w_ge};
      r_cnt <= r_cnt - 1'b1;
      if (w_last) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM receiver: synchronizes the pin, measures period and high time between
// rising edges, and reports rounded duty percent or a stuck-line condition.
module pwm_duty_meter
  import pwm_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 4 * N
) (
  input  logic             clk_main,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [PCT_W-1:0] duty_pct,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             stuck_hi,
  output logic             stuck_lo,
  output logic             overrun
);

  localparam int unsigned      DIV_W   = CNT_W + PCT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);

  logic             r_sync1, r_sync2, r_sync3;
  logic [CNT_W-1:0] r_hi_cnt, r_per_cnt, r_per_lat;
  state_t           r_state, w_next;

  logic             w_rise;
  logic             w_start, w_overrun, w_enter_stuck;
  logic [DIV_W-1:0] w_dividend, w_quo;
  logic             w_div_busy, w_div_done;
  logic [PCT_W-1:0] w_duty;

  assign w_rise = r_sync2 && !r_sync3;

  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // The boundary cycle itself is high, so both counters restart at 1.
  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      r_hi_cnt  <= '0;
      r_per_cnt <= '0;
    end else if (w_rise) begin
      r_hi_cnt  <= CNT_W'(1);
      r_per_cnt <= CNT_W'(1);
    end else begin
      if (r_per_cnt != CNT_MAX) r_per_cnt <= r_per_cnt + 1'b1;
      if (r_sync2 && (r_hi_cnt != CNT_MAX)) r_hi_cnt <= r_hi_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_start       = 1'b0;
    w_overrun     = 1'b0;
    w_enter_stuck = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rise) w_next = MEAS;
      end
      MEAS: begin
        if (w_rise) begin
          if (w_div_busy) w_overrun = 1'b1;
          else            w_start   = 1'b1;
        end else if (r_per_cnt == TO_CNT) begin
          w_enter_stuck = 1'b1;
          w_next        = STUCK;
        end
      end
      STUCK: begin
        if (w_rise) w_next = MEAS;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_dividend = DIV_W'(r_hi_cnt) * DIV_W'(PCT_MAX) + DIV_W'(r_per_cnt[CNT_W-1:1]);

  seq_divider #(
    .DW(CNT_W),
    .QW(DIV_W)
  ) u_div (
    .i_clk      (clk_main),
    .i_rst      (rst),
    .i_start    (w_start),
    .i_abort    (w_enter_stuck),
    .i_dividend (w_dividend),
    .i_divisor  (r_per_cnt),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quo)
  );

  assign w_duty = (w_quo > DIV_W'(PCT_MAX)) ? PCT_W'(PCT_MAX) : w_quo[PCT_W-1:0];

  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      r_per_lat  <= '0;
      duty_pct   <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      stuck_hi   <= 1'b0;
      stuck_lo   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      overrun    <= w_overrun;
      if (w_start) r_per_lat <= r_per_cnt;
      // Stuck entry aborts the divider, so a coincident result is dropped.
      if (w_enter_stuck) begin
        stuck_hi   <= r_sync2;
        stuck_lo   <= !r_sync2;
        duty_pct   <= r_sync2 ? PCT_W'(PCT_MAX) : '0;
        period     <= TO_CNT;
        meas_valid <= 1'b1;
      end else if (w_div_done) begin
        duty_pct   <= w_duty;
        period     <= r_per_lat;
        stuck_hi   <= 1'b0;
        stuck_lo   <= 1'b0;
        meas_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Randomized bench for pwm_duty_meter with a sample-level reference model of
// the measurement rules and a strobe scoreboard.
module tb_pwm_duty_meter;

  localparam int unsigned N       = 512;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 4 * N;

  logic             clk_main = 1'b0;
  logic             rst      = 1'b1;
  logic             pwm_in   = 1'b0;
  logic [6:0]       duty_pct;
  logic [CNT_W-1:0] period;
  logic             meas_valid, stuck_hi, stuck_lo, overrun;

  always #5 clk_main = ~clk_main;

  pwm_duty_meter #(
    .N(N),
    .CNT_W(CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_main   (clk_main),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .duty_pct   (duty_pct),
    .period     (period),
    .meas_valid (meas_valid),
    .stuck_hi   (stuck_hi),
    .stuck_lo   (stuck_lo),
    .overrun    (overrun)
  );

  typedef struct packed {
    logic [6:0]       duty;
    logic [CNT_W-1:0] per;
    logic             shi;
    logic             slo;
  } meas_t;

  meas_t obs_q[$];
  meas_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    ovr_cnt  = 0;

  // Reference model state: active = a rising edge has been seen since reset/stuck.
  bit m_active, m_prev, m_track = 1'b1;
  int m_hi, m_per, m_rises;

  always @(negedge clk_main) begin
    if (!rst) begin
      if (meas_valid) begin
        meas_t m;
        m.duty = duty_pct; m.per = period; m.shi = stuck_hi; m.slo = stuck_lo;
        obs_q.push_back(m);
      end
      if (overrun) ovr_cnt++;
    end
  end

  function automatic meas_t ref_meas(int hi, int per);
    meas_t m;
    int d;
    d = (hi * 100 + per / 2) / per;
    if (d > 100) d = 100;
    m.duty = 7'(d); m.per = CNT_W'(per); m.shi = 1'b0; m.slo = 1'b0;
    return m;
  endfunction

  task automatic model_reset();
    m_active = 0; m_prev = 0; m_hi = 0; m_per = 0; m_rises = 0;
    exp_q.delete(); obs_q.delete(); ovr_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; pwm_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_main);
    #1 rst = 1'b0;
  endtask

  // One pin sample per clock; the model follows the measurement rules per sample.
  task automatic drive_bit(input bit lvl);
    @(posedge clk_main);
    #1 pwm_in = lvl;
    if (lvl && !m_prev) begin
      if (m_active) begin
        m_rises++;
        if (m_track) exp_q.push_back(ref_meas(m_hi, m_per));
      end
      m_active = 1; m_hi = 0; m_per = 0;
    end
    m_prev = lvl;
    if (m_active) begin
      m_per++;
      m_hi += int'(lvl);
      if (m_per > int'(TIMEOUT)) begin
        meas_t s;
        s.duty = lvl ? 7'd100 : 7'd0; s.per = CNT_W'(TIMEOUT); s.shi = lvl; s.slo = !lvl;
        if (m_track) exp_q.push_back(s);
        m_active = 0;
      end
    end
  endtask

  task automatic drive_period(input int h, input int p);
    for (int i = 0; i < p; i++) drive_bit(i < h);
  endtask

  task automatic test_reset();
    rst = 1'b1; pwm_in = 1'b0;
    repeat (2) @(posedge clk_main);
    #1;
    n_checks++;
    if ({duty_pct, period, meas_valid, stuck_hi, stuck_lo, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got duty=%0d per=%0d mv=%b hi=%b lo=%b ovr=%b, expected all 0",
               duty_pct, period, meas_valid, stuck_hi, stuck_lo, overrun);
    end
  endtask

  task automatic test_basic();
    do_reset();
    repeat (4) drive_period(256, 512);
    repeat (40) drive_bit(0);
    n_checks++;
    if (obs_q.size() != 3) begin
      n_fail++; $display("FAIL basic_count: got %0d strobes, expected 3", obs_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL basic_meas[%0d]: got duty=%0d per=%0d hi=%b lo=%b, expected duty=%0d per=%0d hi=%b lo=%b",
                 i, obs_q[i].duty, obs_q[i].per, obs_q[i].shi, obs_q[i].slo,
                 exp_q[i].duty, exp_q[i].per, exp_q[i].shi, exp_q[i].slo);
      end
    end
  endtask

  // Covers 25%, rounding up from 0.58% to 1%, and a period of exactly TIMEOUT.
  task automatic test_rounding();
    do_reset();
    repeat (2) drive_period(128, 512);
    repeat (2) drive_period(3, 512);
    repeat (2) drive_period(1000, TIMEOUT);
    drive_period(256, 512);
    repeat (40) drive_bit(0);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL round_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL round_meas[%0d]: got duty=%0d per=%0d hi=%b lo=%b, expected duty=%0d per=%0d hi=%b lo=%b",
                 i, obs_q[i].duty, obs_q[i].per, obs_q[i].shi, obs_q[i].slo,
                 exp_q[i].duty, exp_q[i].per, exp_q[i].shi, exp_q[i].slo);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    repeat (10) begin
      int p, h;
      p = int'($urandom_range(700, 32));
      h = int'($urandom_range(p - 1, 1));
      drive_period(h, p);
    end
    repeat (40) drive_bit(0);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_meas[%0d]: got duty=%0d per=%0d hi=%b lo=%b, expected duty=%0d per=%0d hi=%b lo=%b",
                 i, obs_q[i].duty, obs_q[i].per, obs_q[i].shi, obs_q[i].slo,
                 exp_q[i].duty, exp_q[i].per, exp_q[i].shi, exp_q[i].slo);
      end
    end
  endtask

  task automatic test_stuck();
    do_reset();
    repeat (2) drive_period(256, 512);
    drive_period(2100, 2100);
    drive_period(0, 100);
    drive_period(256, 512);
    n_checks++;
    if ({stuck_hi, stuck_lo, duty_pct} !== {1'b1, 1'b0, 7'd100}) begin
      n_fail++;
      $display("FAIL stuck_held: got hi=%b lo=%b duty=%0d, expected hi=1 lo=0 duty=100",
               stuck_hi, stuck_lo, duty_pct);
    end
    repeat (2) drive_period(256, 512);
    repeat (40) drive_bit(0);
    n_checks++;
    if (stuck_hi !== 1'b0) begin
      n_fail++; $display("FAIL stuck_cleared: got stuck_hi=%b, expected 0", stuck_hi);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL stuck_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stuck_meas[%0d]: got duty=%0d per=%0d hi=%b lo=%b, expected duty=%0d per=%0d hi=%b lo=%b",
                 i, obs_q[i].duty, obs_q[i].per, obs_q[i].shi, obs_q[i].slo,
                 exp_q[i].duty, exp_q[i].per, exp_q[i].shi, exp_q[i].slo);
      end
    end
  endtask

  // Every boundary seen while measuring either starts a division or overruns.
  task automatic test_overrun();
    do_reset();
    m_track = 1'b0;
    repeat (30) drive_period(5, 10);
    repeat (60) drive_bit(0);
    m_track = 1'b1;
    n_checks++;
    if (ovr_cnt == 0 || obs_q.size() == 0) begin
      n_fail++; $display("FAIL ovr_activity: got %0d overruns %0d strobes, expected both nonzero",
                         ovr_cnt, obs_q.size());
    end
    n_checks++;
    if (obs_q.size() + ovr_cnt != m_rises) begin
      n_fail++; $display("FAIL ovr_accounting: got %0d strobes + %0d overruns, expected %0d boundaries",
                         obs_q.size(), ovr_cnt, m_rises);
    end
    foreach (obs_q[i]) begin
      n_checks++;
      if (obs_q[i] !== ref_meas(5, 10)) begin
        n_fail++; $display("FAIL ovr_meas[%0d]: got duty=%0d per=%0d, expected duty=50 per=10",
                           i, obs_q[i].duty, obs_q[i].per);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (3) drive_period(256, 512);
    repeat (5) drive_bit(1);
    n_checks++;
    if (period !== CNT_W'(512)) begin
      n_fail++; $display("FAIL rstmid_pre: got period=%0d, expected 512", period);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({duty_pct, period, meas_valid, stuck_hi, stuck_lo, overrun} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got duty=%0d per=%0d mv=%b hi=%b lo=%b ovr=%b, expected all 0",
               duty_pct, period, meas_valid, stuck_hi, stuck_lo, overrun);
    end
    pwm_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_main);
    #1 rst = 1'b0;
    repeat (40) drive_bit(0);
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL rstmid_nostrobe: got %0d strobes, expected 0", obs_q.size());
    end
    repeat (3) drive_period(256, 512);
    repeat (40) drive_bit(0);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rstmid_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rstmid_meas[%0d]: got duty=%0d per=%0d, expected duty=%0d per=%0d",
                 i, obs_q[i].duty, obs_q[i].per, exp_q[i].duty, exp_q[i].per);
      end
    end
  endtask

  task automatic test_idle_low();
    do_reset();
    repeat (TIMEOUT + 50) drive_bit(0);
    n_checks++;
    if (obs_q.size() != 0 || stuck_lo !== 1'b0) begin
      n_fail++; $display("FAIL idle_quiet: got %0d strobes stuck_lo=%b, expected 0 strobes stuck_lo=0",
                         obs_q.size(), stuck_lo);
    end
    repeat (3) drive_period(150, 500);
    repeat (40) drive_bit(0);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL idle_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL idle_meas[%0d]: got duty=%0d per=%0d, expected duty=%0d per=%0d",
                 i, obs_q[i].duty, obs_q[i].per, exp_q[i].duty, exp_q[i].per);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_random();
    test_stuck();
    test_overrun();
    test_reset_mid();
    test_idle_low();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
